// File: rtl/axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// axi_rd_arbiter
//
// Shares one AXI3/4 read port between the instruction cache and the data
// cache. Exactly one read transaction is outstanding at a time. Ties are
// broken round-robin. Read data beats go straight through to the owner of
// the transaction, with no buffering.
//
// Ports
//   clk, rst                          clock, asynchronous active-high reset
//   ic_rreq_i/ic_raddr_i/ic_rlen_i    icache request (len = beats - 1)
//   ic_rgrant_o                       one-cycle pulse on the AR handshake
//   ic_rvalid_o/ic_rdata_o/ic_rlast_o icache data beats
//   dc_*                              the same set of ports for the dcache
//   ar*_o, arready_i                  AXI read-address channel
//   rid_i/rdata_i/rresp_i/rlast_i/
//   rvalid_i, rready_o                AXI read-data channel
//   idle_o                            high while no transaction is in flight
//   err_o                             sticky protocol/response error flag
// ---------------------------------------------------------------------------
module axi_rd_arbiter #(
  parameter logic [3:0] IC_ID = 4'd0,
  parameter logic [3:0] DC_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_rreq_i,
  input  logic [31:0] ic_raddr_i,
  input  logic [3:0]  ic_rlen_i,
  output logic        ic_rgrant_o,
  output logic        ic_rvalid_o,
  output logic [31:0] ic_rdata_o,
  output logic        ic_rlast_o,
  input  logic        dc_rreq_i,
  input  logic [31:0] dc_raddr_i,
  input  logic [3:0]  dc_rlen_i,
  output logic        dc_rgrant_o,
  output logic        dc_rvalid_o,
  output logic [31:0] dc_rdata_o,
  output logic        dc_rlast_o,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [7:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic        idle_o,
  output logic        err_o
);

  typedef enum logic [1:0] {S_IDLE, S_AR, S_R} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_dc;   // 1: the most recent grant went to the dcache
  logic        r_owner_dc;  // owner of the transaction in flight
  logic        r_err;
  logic [31:0] r_addr;
  logic [3:0]  r_len;
  logic [3:0]  r_id;
  logic [3:0]  r_cnt;       // beats received so far in this burst

  logic        w_any_req;
  logic        w_pick_dc;
  logic        w_ar_hs;
  logic        w_beat;
  logic        w_beat_err;

  assign w_any_req = ic_rreq_i | dc_rreq_i;
  // On a tie, the side that was not granted last wins.
  assign w_pick_dc = dc_rreq_i & (~ic_rreq_i | ~r_last_dc);
  assign w_ar_hs   = (r_state == S_AR) & arready_i;
  assign w_beat    = (r_state == S_R) & rvalid_i;

  // Detect any bad beat: a last beat at the wrong position, a missing last
  // beat, a wrong ID, or a non-OKAY response.
  assign w_beat_err = w_beat & (( rlast_i & (r_cnt != r_len)) |
                                (~rlast_i & (r_cnt == r_len)) |
                                (rid_i != r_id)               |
                                (rresp_i != 2'b00));

  // State register and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_last_dc  <= 1'b0;
      r_owner_dc <= 1'b0;
      r_err      <= 1'b0;
      r_addr     <= 32'd0;
      r_len      <= 4'd0;
      r_id       <= 4'd0;
      r_cnt      <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_IDLE && w_any_req) begin
        r_owner_dc <= w_pick_dc;
        r_addr     <= w_pick_dc ? dc_raddr_i : ic_raddr_i;
        r_len      <= w_pick_dc ? dc_rlen_i  : ic_rlen_i;
        r_id       <= w_pick_dc ? DC_ID      : IC_ID;
      end
      if (w_ar_hs) begin
        r_last_dc <= r_owner_dc;
        r_cnt     <= 4'd0;
      end
      if (w_beat) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_beat_err) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req)         w_state_next = S_AR;
      S_AR:    if (arready_i)         w_state_next = S_R;
      S_R:     if (rvalid_i & rlast_i) w_state_next = S_IDLE;
      default:                        w_state_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    arid_o      = r_id;
    araddr_o    = r_addr;
    arlen_o     = {4'b0000, r_len};
    arsize_o    = 3'b010;
    arburst_o   = 2'b01;
    arvalid_o   = 1'b0;
    rready_o    = 1'b0;
    ic_rgrant_o = 1'b0;
    dc_rgrant_o = 1'b0;
    ic_rvalid_o = 1'b0;
    ic_rdata_o  = 32'd0;
    ic_rlast_o  = 1'b0;
    dc_rvalid_o = 1'b0;
    dc_rdata_o  = 32'd0;
    dc_rlast_o  = 1'b0;
    idle_o      = (r_state == S_IDLE);
    // Reflect an error on the offending beat itself, then hold it.
    err_o       = r_err | w_beat_err;
    case (r_state)
      S_AR: begin
        arvalid_o   = 1'b1;
        ic_rgrant_o = arready_i & ~r_owner_dc;
        dc_rgrant_o = arready_i &  r_owner_dc;
      end
      S_R: begin
        rready_o = 1'b1;
        if (r_owner_dc) begin
          dc_rvalid_o = rvalid_i;
          dc_rdata_o  = rdata_i;
          dc_rlast_o  = rvalid_i & rlast_i;
        end else begin
          ic_rvalid_o = rvalid_i;
          ic_rdata_o  = rdata_i;
          ic_rlast_o  = rvalid_i & rlast_i;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_rd_arbiter
//
// Self-checking bench for axi_rd_arbiter. The bench plays both caches and the
// AXI slave. Every data beat it drives is pushed to an expected-beat queue. A
// negedge monitor pops an entry each time a cache-side beat appears and
// checks the owner, the data and the last flag.
// ---------------------------------------------------------------------------
module tb_axi_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_rreq_i, dc_rreq_i;
  logic [31:0] ic_raddr_i, dc_raddr_i;
  logic [3:0]  ic_rlen_i, dc_rlen_i;
  logic        ic_rgrant_o, ic_rvalid_o, ic_rlast_o;
  logic        dc_rgrant_o, dc_rvalid_o, dc_rlast_o;
  logic [31:0] ic_rdata_o, dc_rdata_o;
  logic [3:0]  arid_o;
  logic [31:0] araddr_o;
  logic [7:0]  arlen_o;
  logic [2:0]  arsize_o;
  logic [1:0]  arburst_o;
  logic        arvalid_o, arready_i;
  logic [3:0]  rid_i;
  logic [31:0] rdata_i;
  logic [1:0]  rresp_i;
  logic        rlast_i, rvalid_i, rready_o;
  logic        idle_o, err_o;

  int n_checks = 0;
  int n_errors = 0;
  int waited;

  typedef struct {
    bit          dc;
    logic [31:0] data;
    bit          last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;

  always #5 clk = ~clk;

  axi_rd_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_rreq_i(ic_rreq_i), .ic_raddr_i(ic_raddr_i), .ic_rlen_i(ic_rlen_i),
    .ic_rgrant_o(ic_rgrant_o), .ic_rvalid_o(ic_rvalid_o),
    .ic_rdata_o(ic_rdata_o), .ic_rlast_o(ic_rlast_o),
    .dc_rreq_i(dc_rreq_i), .dc_raddr_i(dc_raddr_i), .dc_rlen_i(dc_rlen_i),
    .dc_rgrant_o(dc_rgrant_o), .dc_rvalid_o(dc_rvalid_o),
    .dc_rdata_o(dc_rdata_o), .dc_rlast_o(dc_rlast_o),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o), .arvalid_o(arvalid_o),
    .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: every beat reaching a cache must match the next expected beat.
  always @(negedge clk) begin
    if (ic_rvalid_o || dc_rvalid_o) begin
      if (exp_q.size() == 0) begin
        chk("beat_unexpected", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("beat_owner", {dc_rvalid_o, ic_rvalid_o}, mon_e.dc ? 2 : 1);
        chk("beat_data", mon_e.dc ? dc_rdata_o : ic_rdata_o, mon_e.data);
        chk("beat_last", mon_e.dc ? dc_rlast_o : ic_rlast_o, mon_e.last);
        $display("beat owner=%s data=%08h last=%0d", mon_e.dc ? "dc" : "ic",
                 mon_e.data, mon_e.last);
      end
    end
  end

  // One full transaction as seen from the slave side. last_idx is the beat
  // index carrying rlast, bad_idx a beat with SLVERR, rst_idx a beat during
  // which reset is asserted (-1 disables either).
  task automatic run_txn(input bit exp_dc, input logic [31:0] exp_addr,
                         input logic [3:0] len, input int rdy_dly,
                         input int last_idx, input int bad_idx, input int rst_idx,
                         input bit drop, output int wcyc);
    logic [3:0]  id;
    logic [31:0] d;
    beat_t       e;
    int          nv;
    id = exp_dc ? 4'd1 : 4'd0;
    arready_i = (rdy_dly == 0);
    wcyc = 0;
    do begin
      @(negedge clk);
      wcyc++;
    end while (!arvalid_o && wcyc < 20);
    if (!arvalid_o) begin
      chk("ar_timeout", 0, 1);
      return;
    end
    nv = 1;
    for (int i = 0; i < rdy_dly; i++) begin
      chk("grant_early", {ic_rgrant_o, dc_rgrant_o}, 0);
      chk("araddr_hold", araddr_o, exp_addr);
      @(posedge clk); #1;
      if (i == rdy_dly - 1) arready_i = 1'b1;
      @(negedge clk);
      nv += int'(arvalid_o);
    end
    chk("ar_cycles", nv, rdy_dly + 1);
    chk("grant", {dc_rgrant_o, ic_rgrant_o}, exp_dc ? 2 : 1);
    chk("arid", arid_o, id);
    chk("araddr", araddr_o, exp_addr);
    chk("arlen", arlen_o, {4'b0000, len});
    chk("arsize", arsize_o, 3'b010);
    chk("arburst", arburst_o, 2'b01);
    $display("ar owner=%s addr=%08h len=%0d", exp_dc ? "dc" : "ic", exp_addr, len);
    @(posedge clk); #1;
    arready_i = 1'b0;
    if (drop) begin
      if (exp_dc) dc_rreq_i = 1'b0;
      else        ic_rreq_i = 1'b0;
    end
    for (int b = 0; b <= last_idx; b++) begin
      d        = $urandom;
      rvalid_i = 1'b1;
      rdata_i  = d;
      rid_i    = id;
      rlast_i  = (b == last_idx);
      rresp_i  = (b == bad_idx) ? 2'b10 : 2'b00;
      if (b == rst_idx) begin
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rready", rready_o, 0);
        chk("rst_rvalid", {ic_rvalid_o, dc_rvalid_o}, 0);
        chk("rst_idle", idle_o, 1);
        chk("rst_arvalid", arvalid_o, 0);
        chk("rst_err", err_o, 0);
        @(posedge clk); #1;
        rvalid_i = 1'b0;
        rlast_i  = 1'b0;
        rst      = 1'b0;
        return;
      end
      e.dc = exp_dc; e.data = d; e.last = (b == last_idx);
      exp_q.push_back(e);
      @(negedge clk);
      chk("rready", rready_o, 1);
      if (b == bad_idx || (b == last_idx && last_idx != int'(len)))
        chk("err_on_beat", err_o, 1);
      @(posedge clk); #1;
    end
    rvalid_i = 1'b0;
    rlast_i  = 1'b0;
    rresp_i  = 2'b00;
    @(negedge clk);
    chk("idle_after", idle_o, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ic_rreq_i = 0; dc_rreq_i = 0; ic_raddr_i = 0; dc_raddr_i = 0;
    ic_rlen_i = 0; dc_rlen_i = 0; arready_i = 0;
    rid_i = 0; rdata_i = 0; rresp_i = 0; rlast_i = 0; rvalid_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_idle0", idle_o, 1);
    chk("rst_arvalid0", arvalid_o, 0);
    chk("rst_rready0", rready_o, 0);
    chk("rst_outs0", {ic_rgrant_o, dc_rgrant_o, ic_rvalid_o, dc_rvalid_o,
                      ic_rlast_o, dc_rlast_o, err_o}, 0);
    chk("rst_araddr0", araddr_o, 0);
    chk("rst_arlen0", arlen_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_noreq", idle_o, 1);

    // Icache only, 8 beats, slave ready immediately
    @(posedge clk); #1;
    ic_raddr_i = 32'h1FC0_0000; ic_rlen_i = 4'd7; ic_rreq_i = 1'b1;
    @(negedge clk);
    chk("ar_lat0", arvalid_o, 0);
    run_txn(1'b0, 32'h1FC0_0000, 4'd7, 0, 7, -1, -1, 1'b1, waited);
    chk("ar_lat", waited, 1);

    // Simultaneous requests: dc, ic, dc, ic
    @(posedge clk); #1;
    ic_raddr_i = 32'h0000_1000; ic_rlen_i = 4'd3;
    dc_raddr_i = 32'h0000_2000; dc_rlen_i = 4'd1;
    ic_rreq_i = 1'b1; dc_rreq_i = 1'b1;
    run_txn(1'b1, 32'h0000_2000, 4'd1, 0, 1, -1, -1, 1'b1, waited);
    @(posedge clk); #1;
    dc_rreq_i = 1'b1;
    run_txn(1'b0, 32'h0000_1000, 4'd3, 0, 3, -1, -1, 1'b0, waited);
    run_txn(1'b1, 32'h0000_2000, 4'd1, 0, 1, -1, -1, 1'b1, waited);
    run_txn(1'b0, 32'h0000_1000, 4'd3, 0, 3, -1, -1, 1'b1, waited);

    // AR back-pressure for three cycles
    @(posedge clk); #1;
    ic_raddr_i = 32'h0000_4000; ic_rlen_i = 4'd1; ic_rreq_i = 1'b1;
    run_txn(1'b0, 32'h0000_4000, 4'd1, 3, 1, -1, -1, 1'b1, waited);
    chk("err_clean", err_o, 0);

    // SLVERR on one beat: data still forwarded, error sticky
    @(posedge clk); #1;
    ic_raddr_i = 32'h0000_5000; ic_rlen_i = 4'd3; ic_rreq_i = 1'b1;
    run_txn(1'b0, 32'h0000_5000, 4'd3, 0, 3, 1, -1, 1'b1, waited);
    chk("err_sticky_resp", err_o, 1);

    // Reset in IDLE clears the error
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("err_rst", err_o, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Early rlast from the slave on dcache len 3
    @(posedge clk); #1;
    dc_raddr_i = 32'h0000_6000; dc_rlen_i = 4'd3; dc_rreq_i = 1'b1;
    run_txn(1'b1, 32'h0000_6000, 4'd3, 0, 1, -1, -1, 1'b1, waited);
    chk("err_sticky_last", err_o, 1);
    @(posedge clk); #1;
    ic_raddr_i = 32'h0000_7000; ic_rlen_i = 4'd2; ic_rreq_i = 1'b1;
    run_txn(1'b0, 32'h0000_7000, 4'd2, 0, 2, -1, -1, 1'b1, waited);
    chk("err_still_set", err_o, 1);

    // Reset during beat 3 of an 8-beat burst, then a fresh request
    @(posedge clk); #1;
    ic_raddr_i = 32'h0000_8000; ic_rlen_i = 4'd7; ic_rreq_i = 1'b1;
    run_txn(1'b0, 32'h0000_8000, 4'd7, 0, 7, -1, 2, 1'b1, waited);
    @(posedge clk); #1;
    ic_raddr_i = 32'h0000_9000; ic_rlen_i = 4'd0; ic_rreq_i = 1'b1;
    run_txn(1'b0, 32'h0000_9000, 4'd0, 0, 0, -1, -1, 1'b1, waited);
    chk("err_after_rst", err_o, 0);

    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
